id_ex_stage_reg: RTL and testbench
==================================

# id_ex_stage_reg

Parametrised pipeline-stage register for the ID/EX boundary and any other stage boundary in the core. It carries a generic data payload and a control-signal field under a valid/ready handshake. It supports hazard bubbles (NOP insertion with upstream stall), flush, and a saturating bubble counter for performance monitoring. An optional skid slot gives full throughput with a registered `in_ready`.

## Interface
- `DATA_W`, 101: payload width (register addresses, operand data, immediate).
- `CTRL_W`, 9: control-signal field width.
- `CTRL_NOP`, 0: control value loaded on bubble, flush and reset.
- `ZERO_DATA`, 1: 1 = bubble zeroes the payload; 0 = bubble passes `in_data` through.
- `CNT_W`, 16: bubble counter width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  stage accepts the entry this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `in_ctrl`  in  CTRL_W  upstream control field.
- `bubble`  in  1  hazard request: insert NOP, stall upstream.
- `flush`  in  1  discard all held entries.
- `out_valid`  out  1  output entry present.
- `out_ready`  in  1  downstream consumes the entry.
- `out_data`  out  DATA_W  registered payload.
- `out_ctrl`  out  CTRL_W  registered control field.
- `clr_cnt`  in  1  synchronous clear of `bubble_cnt`.
- `bubble_cnt`  out  CNT_W  number of bubbles inserted, saturating.

## Operation
- Main slot: `out_valid`/`out_data`/`out_ctrl`. `slot_free = !out_valid || out_ready`.
- Priority per cycle: flush > bubble > normal transfer.
- Flush:
  - Next edge: `out_valid`=0, `out_ctrl`=CTRL_NOP, skid slot emptied.
  - `in_ready`=0 during the flush cycle; input is not accepted.
- Bubble:
  - `in_ready`=0 whenever `bubble`=1.
  - `bubble_take = bubble && !flush && slot_free && skid empty`.
  - On take: `out_valid`=1, `out_ctrl`=CTRL_NOP, `out_data` = 0 if ZERO_DATA else `in_data`.
  - Bubble is level-sensitive. If it is not taken, the request waits without being lost. Each cycle with `bubble_take`=1 inserts exactly one NOP.
- Normal: an input transfer (`in_valid && in_ready`) loads the main slot when `slot_free`. Otherwise it loads the skid slot (SKID build only).
- An output transfer (`out_valid && out_ready`) without a new load clears `out_valid`. With the skid slot occupied, the skid entry moves to the main slot instead.
- Counter:
  - `bubble_take` increments `bubble_cnt` and saturates at all-ones.
  - `clr_cnt` zeroes the counter and wins over a same-cycle increment.
  - Flush does not affect the counter.
- Ordering: entries leave in acceptance order. No entry is duplicated or dropped except by flush.

## Timing
- Reset (asynchronous, immediate):
  - `out_valid`=0, `out_data`=0, `out_ctrl`=CTRL_NOP.
  - Skid slot empty, `bubble_cnt`=0.
  - `in_ready`=1 once `rst` deasserts.
- Latency: input accepted at edge N appears at `out_*` after edge N, i.e. in cycle N+1.
- Throughput: one entry per cycle while `out_ready`=1.
- `bubble_cnt` updates one edge after `bubble_take`.
- Reset asserted mid-stream discards the main and skid entries immediately.

## Configuration
- `ID_EX_STAGE_REG_SKID_EN` defined:
  - One-entry skid slot is present.
  - `in_ready = !skid_valid && !bubble && !flush`, with `skid_valid` taken straight from a flop.
  - One extra entry is absorbed when `out_ready` drops.
- Not defined:
  - No skid slot.
  - `in_ready = slot_free && !bubble && !flush`, combinational through `out_ready`.
  - "Skid empty" is treated as always true.

## Test plan
- Reset: assert `rst` mid-stream with `out_valid`=1 → outputs zero/CTRL_NOP immediately, `bubble_cnt`=0, `in_ready`=1 after release.
- Streaming: 8 entries `in_data`=1..8, `out_ready`=1 → outputs 1..8 on consecutive cycles, one cycle late.
- Backpressure: `out_ready`=0 for 3 cycles during streaming.
  - SKID: exactly one extra entry accepted.
  - Non-SKID: zero extra.
  - Both: no loss or duplication after `out_ready`=1.
- Bubble: `bubble`=1 for 2 cycles, `in_valid`=1, `in_data`=0xA → two NOP entries (`out_ctrl`=CTRL_NOP, `out_data`=0) and `in_ready`=0 throughout. Then 0xA is output, and `bubble_cnt`=2.
- Flush with bubble: `flush`=1 and `bubble`=1 in the same cycle, skid full → `out_valid`=0, skid empty, `bubble_cnt` unchanged.
- Saturation: `CNT_W`=2, 5 bubbles → `bubble_cnt`=3; `clr_cnt` together with `bubble` → 0.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: pipeline-stage register with valid/ready handshake, hazard
// bubble insertion, flush and a saturating bubble counter.
// Build option: define ID_EX_STAGE_REG_SKID_EN to add a one-entry skid slot,
// which gives full throughput with in_ready driven straight from a flop.
module id_ex_stage_reg #(
    parameter int unsigned       DATA_W    = 101,
    parameter int unsigned       CTRL_W    = 9,
    parameter logic [CTRL_W-1:0] CTRL_NOP  = '0,
    parameter bit                ZERO_DATA = 1'b1,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              slot_free;
    logic              skid_empty;
    logic              bubble_take;
    logic              in_xfer;
    logic              out_xfer;
    logic [DATA_W-1:0] bubble_data;

`ifdef ID_EX_STAGE_REG_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
`endif

    // Handshake and hazard qualifiers
    always_comb begin
        slot_free = !out_valid_q || out_ready;
`ifdef ID_EX_STAGE_REG_SKID_EN
        skid_empty = !skid_valid_q;
        // Registered ready: depends only on the skid flop and the hazard inputs
        in_ready   = !skid_valid_q && !bubble && !flush;
`else
        skid_empty = 1'b1;
        in_ready   = slot_free && !bubble && !flush;
`endif
        bubble_take = bubble && !flush && slot_free && skid_empty;
        in_xfer     = in_valid && in_ready;
        out_xfer    = out_valid_q && out_ready;
        bubble_data = ZERO_DATA ? '0 : in_data;
    end

    // Next state of the main slot (and skid slot): flush > bubble > transfer
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ctrl_d  = out_ctrl_q;
`ifdef ID_EX_STAGE_REG_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
`endif
        if (flush) begin
            out_valid_d = 1'b0;
            out_ctrl_d  = CTRL_NOP;
`ifdef ID_EX_STAGE_REG_SKID_EN
            skid_valid_d = 1'b0;
`endif
        end else if (bubble_take) begin
            out_valid_d = 1'b1;
            out_data_d  = bubble_data;
            out_ctrl_d  = CTRL_NOP;
        end else begin
`ifdef ID_EX_STAGE_REG_SKID_EN
            // An occupied skid implies in_ready=0, so only the drain path applies
            if (skid_valid_q) begin
                if (slot_free) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = skid_data_q;
                    out_ctrl_d   = skid_ctrl_q;
                    skid_valid_d = 1'b0;
                end
            end else
`endif
            if (in_xfer && slot_free) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
                out_ctrl_d  = in_ctrl;
            end
`ifdef ID_EX_STAGE_REG_SKID_EN
            else if (in_xfer) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
                skid_ctrl_d  = in_ctrl;
            end
`endif
            else if (out_xfer) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Saturating bubble counter; clear wins over a same-cycle increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (bubble_take && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ctrl_q  <= CTRL_NOP;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ctrl_q  <= out_ctrl_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef ID_EX_STAGE_REG_SKID_EN
    // Skid slot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= CTRL_NOP;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end
`endif

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_ctrl   = out_ctrl_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed and random stimulus against a queue-based model.
// A second instance with a 2-bit counter shares all inputs to exercise saturation.
module tb_id_ex_stage_reg;

    localparam int unsigned       DATA_W    = 101;
    localparam int unsigned       CTRL_W    = 9;
    localparam logic [CTRL_W-1:0] CTRL_NOP  = '0;
    localparam bit                ZERO_DATA = 1'b1;
`ifdef ID_EX_STAGE_REG_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic              clk, rst;
    logic              in_valid, in_ready, in_ready2;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              bubble, flush, out_ready, clr_cnt;
    logic              out_valid, out_valid2;
    logic [DATA_W-1:0] out_data, out_data2;
    logic [CTRL_W-1:0] out_ctrl, out_ctrl2;
    logic [15:0]       bubble_cnt;
    logic [1:0]        bubble_cnt2;

    int checks = 0;
    int errors = 0;

    // Model: queue of held entries (front = main slot, second = skid)
    logic [DATA_W+CTRL_W-1:0] mq[$];
    int cnt16 = 0;
    int cnt2  = 0;

    id_ex_stage_reg #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP),
        .ZERO_DATA(ZERO_DATA), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .bubble(bubble), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .clr_cnt(clr_cnt), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage_reg #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP),
        .ZERO_DATA(ZERO_DATA), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_ctrl(in_ctrl), .bubble(bubble), .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_ctrl(out_ctrl2), .clr_cnt(clr_cnt), .bubble_cnt(bubble_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_ready();
        if (flush || bubble) return 1'b0;
        if (SKID) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    task automatic check_all();
        chk("out_valid", out_valid, mq.size() > 0);
        chk("in_ready", in_ready, exp_ready());
        chk("bubble_cnt", bubble_cnt, cnt16);
        chk("bubble_cnt_w2", bubble_cnt2, cnt2);
        if (mq.size() > 0) begin
            chk("out_data", out_data, mq[0][DATA_W+CTRL_W-1:CTRL_W]);
            chk("out_ctrl", out_ctrl, mq[0][CTRL_W-1:0]);
        end
    endtask

    task automatic model_update();
        bit rdy;
        bit take;
        logic [DATA_W-1:0] bd;
        rdy  = exp_ready();
        take = 1'b0;
        bd   = ZERO_DATA ? '0 : in_data;
        if (flush) begin
            mq.delete();
        end else begin
            take = bubble && (mq.size() == 0 || out_ready) && (mq.size() < 2);
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (take) mq.push_back({bd, CTRL_NOP});
            else if (in_valid && rdy) mq.push_back({in_data, in_ctrl});
        end
        if (clr_cnt) begin
            cnt16 = 0;
            cnt2  = 0;
        end else if (take) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt2 < 3) cnt2++;
        end
    endtask

    // Check at negedge, advance the model, then return 1 time unit after posedge
    task automatic tick();
        @(negedge clk);
        check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DATA_W-1:0];
    endfunction

    initial begin
        int acc;
        int saved;
        rst = 1'b1; in_valid = 0; in_data = '0; in_ctrl = '0;
        bubble = 0; flush = 0; out_ready = 0; clr_cnt = 0;
        @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_ctrl", out_ctrl, CTRL_NOP);
        chk("rst_cnt", bubble_cnt, '0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Streaming 1..8, one cycle latency
        in_valid = 1; out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            in_data = DATA_W'(i);
            in_ctrl = CTRL_W'(i + 16);
            tick();
            chk("stream_data", out_data, i);
            chk("stream_valid", out_valid, 1'b1);
        end
        in_valid = 0;
        tick();

        // Asynchronous reset mid-stream
        in_valid = 1; in_data = DATA_W'(85); in_ctrl = CTRL_W'(3); out_ready = 0;
        tick();
        if (SKID) tick();
        chk("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_out_data", out_data, '0);
        chk("mid_rst_out_ctrl", out_ctrl, CTRL_NOP);
        chk("mid_rst_cnt", bubble_cnt, '0);
        mq.delete(); cnt16 = 0; cnt2 = 0;
        in_valid = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Backpressure: three stalled cycles while input stays valid
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 2; i++) begin
            in_data = DATA_W'(256 + i);
            tick();
        end
        in_data = DATA_W'(512);
        out_ready = 0;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (in_ready && in_valid) acc++;
            tick();
            if (acc > 0) in_data = DATA_W'(512 + acc);
        end
        chk("bp_extra", acc, SKID ? 1 : 0);
        out_ready = 1; in_valid = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_drained", out_valid, 1'b0);

        // Bubble for two cycles with a pending input
        clr_cnt = 1; tick(); clr_cnt = 0;
        in_valid = 1; in_data = DATA_W'(10); in_ctrl = CTRL_W'(5); bubble = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bubble_in_ready", in_ready, 1'b0);
            tick();
            chk("bubble_valid", out_valid, 1'b1);
            chk("bubble_ctrl", out_ctrl, CTRL_NOP);
            chk("bubble_data", out_data, '0);
        end
        bubble = 0;
        tick();
        chk("after_bubble_data", out_data, 10);
        chk("after_bubble_ctrl", out_ctrl, 5);
        chk("bubble_cnt_two", bubble_cnt, 2);
        in_valid = 0;
        tick();

        // Flush together with bubble while all slots are full
        out_ready = 0; in_valid = 1; in_data = DATA_W'(77); in_ctrl = CTRL_W'(7);
        tick();
        in_data = DATA_W'(78);
        tick();
        saved = cnt16;
        flush = 1; bubble = 1;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        tick();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ctrl", out_ctrl, CTRL_NOP);
        chk("flush_cnt", bubble_cnt, saved);
        flush = 0; bubble = 0; in_valid = 0;
        #1;
        chk("flush_skid_empty", in_ready, 1'b1);
        tick();

        // Saturation of the 2-bit counter, then clear beats increment
        out_ready = 1;
        clr_cnt = 1; tick(); clr_cnt = 0;
        bubble = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("sat_cnt_w2", bubble_cnt2, 3);
        chk("sat_cnt_w16", bubble_cnt, 5);
        clr_cnt = 1;
        tick();
        chk("clr_cnt_w2", bubble_cnt2, 0);
        chk("clr_cnt_w16", bubble_cnt, 0);
        clr_cnt = 0; bubble = 0;
        tick();

        // Random traffic checked against the model every cycle
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            bubble    = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            clr_cnt   = ($urandom_range(0, 29) == 0);
            in_data   = rand_data();
            in_ctrl   = CTRL_W'($urandom);
            tick();
        end
        in_valid = 0; bubble = 0; flush = 0; clr_cnt = 0; out_ready = 1;
        for (int i = 0; i < 3; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
